// File: rtl/cpu_mcycle_sequencer.sv
// M-cycle/T-phase bus sequencer: walks the active control word through its machine cycles,
// drives the registered memory bus, inserts wait-states with timeout and handles HALT/IRQ at boundaries.
module cpu_mcycle_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int T_PER_M    = 4,
    parameter int MAX_CYCLES = 6,
    parameter int MAX_WAIT   = 15,
    parameter int CYC_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CYC_W:0]    cw_num_cycles,
    input  logic [ADDR_W-1:0] cyc_addr,
    input  logic [1:0]        cyc_op,
    input  logic [DATA_W-1:0] cyc_wdata,
    input  logic              cyc_cond_check,
    input  logic              cyc_cond_pass,
    input  logic              halt_req,
    input  logic              irq_pending,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_read_en,
    output logic              bus_write_en,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              exec_strobe,
    output logic [CYC_W-1:0]  cycle_idx,
    output logic [2:0]        t_phase,
    output logic              instr_boundary,
    output logic              irq_taken,
    output logic              halted,
    output logic              bus_error
);

    localparam logic [2:0]     DP    = 3'(T_PER_M - 2);
    localparam logic [2:0]     LP    = 3'(T_PER_M - 1);
    localparam int             WC_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CYC_W:0] MAXC  = (CYC_W + 1)'(MAX_CYCLES);
    localparam logic [1:0]     OP_RD = 2'b01;
    localparam logic [1:0]     OP_WR = 2'b10;

    typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

    state_t            state, state_n;
    logic [WC_W-1:0]   wait_cnt, wait_n;
    logic [2:0]        t_n;
    logic [CYC_W-1:0]  cyc_n, last_idx;
    logic [CYC_W:0]    ncyc;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n, rdata_n;
    logic              rd_en_n, wr_en_n, rvalid_n, bound_n, irq_n, halted_n, err_n;
    logic              is_access;

    // 0 behaves as a single-cycle word; oversize counts clamp to the hardware limit
    always_comb begin
        ncyc = cw_num_cycles;
        if (cw_num_cycles == '0)
            ncyc = (CYC_W + 1)'(1);
        else if (cw_num_cycles > MAXC)
            ncyc = MAXC;
    end

    assign last_idx    = CYC_W'(ncyc - (CYC_W + 1)'(1));
    assign is_access   = (cyc_op == OP_RD) || (cyc_op == OP_WR);
    assign exec_strobe = (state == RUN) && (t_phase == LP);

    always_comb begin
        state_n  = state;
        t_n      = t_phase;
        cyc_n    = cycle_idx;
        wait_n   = wait_cnt;
        addr_n   = bus_addr;
        rd_en_n  = bus_read_en;
        wr_en_n  = bus_write_en;
        wdata_n  = bus_wdata;
        rdata_n  = rd_data;
        rvalid_n = 1'b0;
        bound_n  = 1'b0;
        irq_n    = 1'b0;
        halted_n = halted;
        err_n    = 1'b0;
        case (state)
            RUN: begin
                t_n = t_phase + 3'd1;
                if (t_phase == 3'd0)
                    addr_n = cyc_addr;
                if (t_phase == 3'd1) begin
                    rd_en_n = (cyc_op == OP_RD);
                    wr_en_n = (cyc_op == OP_WR);
                    if (cyc_op == OP_WR)
                        wdata_n = cyc_wdata;
                end
                if (t_phase == DP && is_access) begin
                    if (MAX_WAIT == 0 || bus_ready) begin
                        if (cyc_op == OP_RD) begin
                            rdata_n  = bus_rdata;
                            rvalid_n = 1'b1;
                        end
                    end else begin
                        // the DP clock itself is the first stall clock
                        state_n = WAIT;
                        t_n     = DP;
                        wait_n  = WC_W'(1);
                    end
                end
                if (t_phase == LP) begin
                    t_n     = 3'd0;
                    rd_en_n = 1'b0;
                    wr_en_n = 1'b0;
                    if (cyc_cond_check && !cyc_cond_pass && cycle_idx < last_idx) begin
                        cyc_n = last_idx;
                    end else if (({1'b0, cycle_idx} + (CYC_W + 1)'(1)) >= ncyc) begin
                        cyc_n   = '0;
                        bound_n = 1'b1;
                        if (irq_pending) begin
                            irq_n = 1'b1;
                        end else if (halt_req) begin
                            state_n  = HALT;
                            halted_n = 1'b1;
                        end
                    end else begin
                        cyc_n = cycle_idx + CYC_W'(1);
                    end
                end
            end
            WAIT: begin
                // ready on the timeout clock still counts as a successful access
                if (bus_ready) begin
                    if (bus_read_en) begin
                        rdata_n  = bus_rdata;
                        rvalid_n = 1'b1;
                    end
                    wait_n  = '0;
                    state_n = RUN;
                    t_n     = LP;
                end else if (wait_cnt >= WC_W'(MAX_WAIT)) begin
                    err_n = 1'b1;
                    if (bus_read_en) begin
                        rdata_n  = '1;
                        rvalid_n = 1'b1;
                    end
                    wait_n  = '0;
                    state_n = RUN;
                    t_n     = LP;
                end else begin
                    wait_n = wait_cnt + WC_W'(1);
                end
            end
            HALT: begin
                t_n   = 3'd0;
                cyc_n = '0;
                if (irq_pending) begin
                    state_n  = RUN;
                    halted_n = 1'b0;
                end
            end
            default: begin
                state_n = RUN;
                t_n     = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            wait_cnt       <= '0;
            t_phase        <= 3'd0;
            cycle_idx      <= '0;
            bus_addr       <= '0;
            bus_read_en    <= 1'b0;
            bus_write_en   <= 1'b0;
            bus_wdata      <= '0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            instr_boundary <= 1'b0;
            irq_taken      <= 1'b0;
            halted         <= 1'b0;
            bus_error      <= 1'b0;
        end else begin
            state          <= state_n;
            wait_cnt       <= wait_n;
            t_phase        <= t_n;
            cycle_idx      <= cyc_n;
            bus_addr       <= addr_n;
            bus_read_en    <= rd_en_n;
            bus_write_en   <= wr_en_n;
            bus_wdata      <= wdata_n;
            rd_data        <= rdata_n;
            rd_valid       <= rvalid_n;
            instr_boundary <= bound_n;
            irq_taken      <= irq_n;
            halted         <= halted_n;
            bus_error      <= err_n;
        end
    end

endmodule
